// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Serialises whole-line bursts from three cache requesters onto one
//   external memory port.
//   Priority is D-write > D-read > I-read.
//   The I-cache has a starvation override after STARVE_LIMIT D-side bursts.
//   Only one burst is outstanding at a time.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   ic_rd_*            I-cache fill: req/addr in; ack/data_valid out
//   dc_rd_*            D-cache fill: req/addr in; ack/data_valid out
//   rd_data            read beat broadcast to both caches
//   dc_wr_*            D-cache writeback: req/addr/data in; ack/data_ready out
//   mem_*              memory controller address phase, write beats, read beats
//   grant              0 none, 1 I-read, 2 D-read, 3 D-write
//   busy               arbiter is not IDLE
//   perf_*             32-bit saturating counters
//
// Optional feature macro: MEM_ARB_PERF_EN
//   When defined, the perf_* counters are built.
//   When not defined, the perf_* ports are tied to 0.
module mem_port_arbiter #(
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 32,
    parameter int BURST_LEN    = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_rd_req,
    input  logic [ADDR_W-1:0] ic_rd_addr,
    output logic              ic_rd_ack,
    output logic              ic_rd_data_valid,
    input  logic              dc_rd_req,
    input  logic [ADDR_W-1:0] dc_rd_addr,
    output logic              dc_rd_ack,
    output logic              dc_rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              dc_wr_req,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [DATA_W-1:0] dc_wr_data,
    output logic              dc_wr_data_ready,
    output logic              dc_wr_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wdata_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [31:0]       perf_ic_bursts,
    output logic [31:0]       perf_dc_bursts,
    output logic [31:0]       perf_ic_wait_cycles
);

    localparam int BW = $clog2(BURST_LEN);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_LEN - 1);

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IC   = 2'd1;
    localparam logic [1:0] GNT_DR   = 2'd2;
    localparam logic [1:0] GNT_DW   = 2'd3;

    typedef enum logic [1:0] {IDLE, ADDR, RDATA, WDATA} state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;

    logic       force_ic;
    logic [1:0] winner;
    logic       burst_done;

    // The starvation override takes precedence over the fixed order.
    assign force_ic = (STARVE_LIMIT != 0) && ic_rd_req && (starve_cnt_q >= STARVE_MAX);

    always_comb begin
        winner = GNT_NONE;
        if (force_ic)       winner = GNT_IC;
        else if (dc_wr_req) winner = GNT_DW;
        else if (dc_rd_req) winner = GNT_DR;
        else if (ic_rd_req) winner = GNT_IC;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        beat_cnt_d   = beat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        burst_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (winner != GNT_NONE) begin
                    state_d = ADDR;
                    grant_d = winner;
                    we_d    = (winner == GNT_DW);
                    addr_d  = (winner == GNT_DW) ? dc_wr_addr :
                              (winner == GNT_DR) ? dc_rd_addr : ic_rd_addr;
                    if (winner == GNT_IC) starve_cnt_d = '0;
                end
            end
            ADDR: begin
                if (mem_ack) state_d = we_q ? WDATA : RDATA;
            end
            RDATA, WDATA: begin
                // Both data phases count beats the same way; only the qualifier differs.
                if ((state_q == RDATA) ? mem_rdata_valid : mem_wdata_ready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        burst_done = 1'b1;
                        state_d    = IDLE;
                        grant_d    = GNT_NONE;
                        we_d       = 1'b0;
                        addr_d     = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A finished D-side burst counts against a waiting I-cache.
        if (burst_done && grant_q != GNT_IC && ic_rd_req && starve_cnt_q < STARVE_MAX)
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= GNT_NONE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            beat_cnt_q   <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            beat_cnt_q   <= beat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign busy             = (state_q != IDLE);
    assign grant            = grant_q;
    assign mem_req          = (state_q == ADDR);
    assign mem_we           = we_q;
    assign mem_addr         = addr_q;
    assign mem_wdata        = dc_wr_data;
    assign rd_data          = mem_rdata;
    assign ic_rd_ack        = mem_req && mem_ack && (grant_q == GNT_IC);
    assign dc_rd_ack        = mem_req && mem_ack && (grant_q == GNT_DR);
    assign dc_wr_ack        = mem_req && mem_ack && (grant_q == GNT_DW);
    assign ic_rd_data_valid = (state_q == RDATA) && mem_rdata_valid && (grant_q == GNT_IC);
    assign dc_rd_data_valid = (state_q == RDATA) && mem_rdata_valid && (grant_q == GNT_DR);
    assign dc_wr_data_ready = (state_q == WDATA) && mem_wdata_ready;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_ic_bursts_q, perf_ic_bursts_d;
    logic [31:0] perf_dc_bursts_q, perf_dc_bursts_d;
    logic [31:0] perf_ic_wait_q, perf_ic_wait_d;

    always_comb begin
        perf_ic_bursts_d = perf_ic_bursts_q;
        perf_dc_bursts_d = perf_dc_bursts_q;
        perf_ic_wait_d   = perf_ic_wait_q;
        if (ic_rd_ack && perf_ic_bursts_q != '1)
            perf_ic_bursts_d = perf_ic_bursts_q + 1'b1;
        if ((dc_rd_ack || dc_wr_ack) && perf_dc_bursts_q != '1)
            perf_dc_bursts_d = perf_dc_bursts_q + 1'b1;
        if (ic_rd_req && !ic_rd_ack && perf_ic_wait_q != '1)
            perf_ic_wait_d = perf_ic_wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ic_bursts_q <= '0;
            perf_dc_bursts_q <= '0;
            perf_ic_wait_q   <= '0;
        end else begin
            perf_ic_bursts_q <= perf_ic_bursts_d;
            perf_dc_bursts_q <= perf_dc_bursts_d;
            perf_ic_wait_q   <= perf_ic_wait_d;
        end
    end

    assign perf_ic_bursts      = perf_ic_bursts_q;
    assign perf_dc_bursts      = perf_dc_bursts_q;
    assign perf_ic_wait_cycles = perf_ic_wait_q;
`else
    assign perf_ic_bursts      = '0;
    assign perf_dc_bursts      = '0;
    assign perf_ic_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter.
//   The bench drives inputs on the falling edge.
//   It samples outputs 1ns later.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_rd_req, dc_rd_req, dc_wr_req;
    logic [25:0] ic_rd_addr, dc_rd_addr, dc_wr_addr;
    logic        ic_rd_ack, ic_rd_data_valid, dc_rd_ack, dc_rd_data_valid;
    logic [31:0] rd_data, dc_wr_data, mem_wdata, mem_rdata;
    logic        dc_wr_data_ready, dc_wr_ack;
    logic        mem_req, mem_we, mem_ack, mem_wdata_ready, mem_rdata_valid;
    logic [25:0] mem_addr;
    logic [1:0]  grant;
    logic        busy;
    logic [31:0] perf_ic_bursts, perf_dc_bursts, perf_ic_wait_cycles;

    int checks = 0;
    int failures = 0;
    logic [31:0] wd [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_ack(ic_rd_ack),
        .ic_rd_data_valid(ic_rd_data_valid),
        .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_ack(dc_rd_ack),
        .dc_rd_data_valid(dc_rd_data_valid), .rd_data(rd_data),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
        .dc_wr_data_ready(dc_wr_data_ready), .dc_wr_ack(dc_wr_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_wdata(mem_wdata), .mem_wdata_ready(mem_wdata_ready),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .grant(grant), .busy(busy),
        .perf_ic_bursts(perf_ic_bursts), .perf_dc_bursts(perf_dc_bursts),
        .perf_ic_wait_cycles(perf_ic_wait_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plays the memory side and the granted requester for one burst.
    // The caller must be on a falling edge with the requests already set up.
    task automatic burst(input logic [1:0] g, input logic [25:0] addr, input int ack_dly,
                         input logic spur, input logic keep_dc, input logic [31:0] base);
        int w = 0;
        int idx = 0;
        int cyc = 0;
        logic rdy = 1'b1;
        while (!mem_req && w < 20) begin @(negedge clk); w++; end
        chk("req_latency", w, 1);
        chk("grant", {30'd0, grant}, {30'd0, g});
        chk("mem_addr", {6'd0, mem_addr}, {6'd0, addr});
        chk("mem_we", {31'd0, mem_we}, {31'd0, g == 2'd3});
        repeat (ack_dly) begin
            mem_rdata_valid = spur;
            #1;
            chk("spur_valid", {30'd0, ic_rd_data_valid, dc_rd_data_valid}, 0);
            chk("spur_beat", {30'd0, dut.beat_cnt_q}, 0);
            @(negedge clk);
        end
        mem_rdata_valid = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("acks", {29'd0, ic_rd_ack, dc_rd_ack, dc_wr_ack},
            {29'd0, g == 2'd1, g == 2'd2, g == 2'd3});
        @(negedge clk);
        mem_ack = 1'b0;
        if (g == 2'd1) ic_rd_req = 1'b0;
        if (g == 2'd2 && !keep_dc) dc_rd_req = 1'b0;
        if (g == 2'd3) dc_wr_req = 1'b0;
        #1;
        chk("req_drop", {31'd0, mem_req}, 0);
        if (g != 2'd3) begin
            for (int i = 0; i < 4; i++) begin
                mem_rdata_valid = 1'b1;
                mem_rdata = base + i;
                #1;
                chk("rd_valid", {30'd0, ic_rd_data_valid, dc_rd_data_valid},
                    {30'd0, g == 2'd1, g == 2'd2});
                chk("rd_data", rd_data, base + i);
                @(negedge clk);
            end
            mem_rdata_valid = 1'b0;
        end else begin
            while (idx < 4 && cyc < 20) begin
                mem_wdata_ready = rdy;
                #1;
                chk("wr_ready", {31'd0, dc_wr_data_ready}, {31'd0, rdy});
                chk("wdata", mem_wdata, wd[idx]);
                if (rdy) idx++;
                @(negedge clk);
                dc_wr_data = wd[idx & 3];
                rdy = !rdy;
                cyc++;
            end
            mem_wdata_ready = 1'b0;
            chk("wr_beats", idx, 4);
        end
        #1;
        chk("idle_after", {31'd0, busy}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;
        ic_rd_addr = 26'h100; dc_rd_addr = 26'h200; dc_wr_addr = 26'h300;
        dc_wr_data = wd[0];
        mem_ack = 0; mem_wdata_ready = 0; mem_rdata = 0; mem_rdata_valid = 0;
        #1;
        chk("rst_out", {25'd0, busy, grant, mem_req, mem_we, ic_rd_ack, dc_wr_data_ready}, 0);
        chk("rst_addr", {6'd0, mem_addr}, 0);
        chk("rst_perf", perf_ic_bursts | perf_dc_bursts | perf_ic_wait_cycles, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // A stray read beat while IDLE must be ignored.
        mem_rdata_valid = 1'b1;
        #1;
        chk("idle_spur", {30'd0, ic_rd_data_valid, dc_rd_data_valid}, 0);
        @(negedge clk);
        mem_rdata_valid = 1'b0;
        chk("idle_beat", {30'd0, dut.beat_cnt_q}, 0);

        // Single I-read, ack after 2 cycles, stray beats while in ADDR.
        ic_rd_req = 1'b1;
        burst(2'd1, 26'h100, 2, 1'b1, 1'b0, 32'hA0);

        // Three simultaneous requests are served in priority order.
        ic_rd_req = 1; dc_rd_req = 1; dc_wr_req = 1;
        burst(2'd3, 26'h300, 1, 1'b0, 1'b0, 32'h0);
        burst(2'd2, 26'h200, 0, 1'b0, 1'b0, 32'hB0);
        burst(2'd1, 26'h100, 0, 1'b0, 1'b0, 32'hC0);
        chk("starve_clr0", {29'd0, dut.starve_cnt_q}, 0);

        // Starvation: 4 D-reads, then I-read wins against a held D-read.
        ic_rd_req = 1; dc_rd_req = 1;
        for (int k = 0; k < 4; k++) burst(2'd2, 26'h200, 0, 1'b0, 1'b1, 32'hD0);
        chk("starve_sat", {29'd0, dut.starve_cnt_q}, 4);
        burst(2'd1, 26'h100, 0, 1'b0, 1'b0, 32'hE0);
        dc_rd_req = 1'b0;
        chk("starve_clr", {29'd0, dut.starve_cnt_q}, 0);
        @(negedge clk);

        // Reset asserted after the 2nd beat of a read burst.
        ic_rd_req = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; ic_rd_req = 1'b0;
        repeat (2) begin mem_rdata_valid = 1'b1; @(negedge clk); end
        rst_n = 1'b0;
        #1;
        chk("arst_out", {27'd0, busy, grant, mem_req, ic_rd_data_valid}, 0);
        chk("arst_beat", {30'd0, dut.beat_cnt_q}, 0);
        chk("arst_perf", perf_ic_bursts | perf_dc_bursts | perf_ic_wait_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1; mem_rdata_valid = 1'b0;
        @(negedge clk);
        ic_rd_req = 1'b1;
        burst(2'd1, 26'h100, 1, 1'b0, 1'b0, 32'hF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single external memory port between the three core-side burst requesters: I-cache line fill, D-cache line fill, and D-cache line writeback. The block sits between the caches and the memory controller and serialises whole-line bursts. Fixed priority applies (D-write > D-read > I-read), with an anti-starvation override for the I-cache. Exactly one burst is outstanding at a time.

Parameters:
ADDR_W, 26, byte-address width of all request addresses
DATA_W, 32, beat width
BURST_LEN, 4, beats per line burst (power of two, >=2)
STARVE_LIMIT, 4, D-side bursts completed while I-read waits before I-read is forced to win; 0 disables the override

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ic_rd_req  in  1  I-cache fill request, held until ic_rd_ack
ic_rd_addr  in  ADDR_W  I-cache line address
ic_rd_ack  out  1  one-cycle pulse, request accepted by memory
ic_rd_data_valid  out  1  beat valid for I-cache
dc_rd_req / dc_rd_addr / dc_rd_ack / dc_rd_data_valid  same meaning, D-cache fill
rd_data  out  DATA_W  read beat, broadcast to both caches (= mem_rdata)
dc_wr_req  in  1  D-cache writeback request, held until dc_wr_ack
dc_wr_addr  in  ADDR_W  writeback line address
dc_wr_data  in  DATA_W  current write beat
dc_wr_data_ready  out  1  current write beat consumed; requester advances
dc_wr_ack  out  1  one-cycle pulse, writeback accepted
mem_req  out  1  address-phase request
mem_we  out  1  1 = write burst
mem_addr  out  ADDR_W  burst address
mem_ack  in  1  address phase accepted
mem_wdata  out  DATA_W  write beat (= dc_wr_data)
mem_wdata_ready  in  1  memory consumes mem_wdata this cycle
mem_rdata  in  DATA_W  read beat
mem_rdata_valid  in  1  read beat valid
grant  out  2  0 none, 1 I-read, 2 D-read, 3 D-write
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; grant, busy, mem_req, mem_we, mem_addr, all acks/valids/readys = 0; beat and starve counters = 0. Reset asserted mid-burst aborts the burst immediately; the memory side is reset by the same rst_n.
- States: IDLE, ADDR, RDATA, WDATA.
- IDLE: if any req is high, register the winner's grant/addr/we and enter ADDR next cycle. Arbitration latency is 1 cycle from req to mem_req.
- Winner selection: if ic_rd_req and starve_cnt >= STARVE_LIMIT (and STARVE_LIMIT != 0), the winner is I-read. Otherwise D-write > D-read > I-read.
- ADDR: mem_req=1; mem_addr and mem_we are stable until mem_ack. On the cycle mem_ack=1, pulse the granted requester's ack combinationally in the same cycle, clear mem_req next cycle, then go to RDATA (read) or WDATA (write).
- RDATA: each cycle with mem_rdata_valid=1 asserts the granted *_rd_data_valid combinationally and increments beat_cnt. The beat with beat_cnt==BURST_LEN-1 returns the block to IDLE and clears beat_cnt. mem_rdata_valid in any other state is ignored.
- WDATA: dc_wr_data_ready = mem_wdata_ready, combinational. Beats are counted identically; the last beat returns the block to IDLE.
- Minimum back-to-back spacing: the cycle after the last beat is IDLE; the next mem_req follows one cycle later.
- starve_cnt: increments (saturating at STARVE_LIMIT) on completion of each D-side burst while ic_rd_req=1. It clears when I-read is granted.
- A requester dropping req before its ack is a protocol violation; the arbiter still completes the burst using the registered address.
- Simultaneous new requests arriving during a burst are not sampled until IDLE.

Optional Feature:
MEM_ARB_PERF_EN: when defined, adds 32-bit saturating counters perf_ic_bursts, perf_dc_bursts, and perf_ic_wait_cycles (cycles with ic_rd_req=1 and ic_rd_ack=0), cleared by reset, on output ports of the same names. When not defined, the ports remain and are tied to 0, and no counter logic exists.

Test Plan:
- Single I-read at 0x000100, mem_ack after 2 cycles, 4 rdata beats 0xA0..0xA3 -> ic_rd_ack 1 pulse; ic_rd_data_valid 4 times with rd_data 0xA0..0xA3; dc_rd_data_valid never high; return to IDLE; busy=0.
- ic_rd_req, dc_rd_req, and dc_wr_req all asserted in the same cycle -> grant order 3, 2, 1; mem_we=1 only on the first burst; one IDLE cycle between bursts.
- D-write of 0x11,0x22,0x33,0x44 with mem_wdata_ready toggling 1,0,1,0... -> mem_wdata advances only on ready cycles; dc_wr_data_ready mirrors it; exit after the 4th consumed beat.
- STARVE_LIMIT=4, ic_rd_req held while D-read is re-requested continuously -> exactly 4 D-read bursts, then I-read granted even with dc_rd_req=1; starve_cnt=0 afterwards.
- mem_rdata_valid pulsed during IDLE and ADDR -> no *_rd_data_valid pulse; beat_cnt unchanged.
- rst_n asserted after the 2nd beat of a read burst -> all outputs 0 asynchronously; after release, a new request starts a fresh 4-beat burst. With MEM_ARB_PERF_EN, perf counters read 0 after reset.
